// File: rtl/irq_trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: cause codes, interrupt bit positions,
// FSM encoding and the trap-vector computation.
package irq_trap_sequencer_pkg;

  // Machine interrupt codes; also their bit positions in mie/mip.
  localparam int unsigned IrqMsi = 3;
  localparam int unsigned IrqMti = 7;
  localparam int unsigned IrqMei = 11;

  localparam int unsigned CauseCodeW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StCommit,
    StRedirect
  } state_e;

  // Direct mode always; vectored mode (mtvec[1:0] == 01) offsets interrupts by 4 * code.
  function automatic logic [31:0] trap_vector(logic [31:0] mtvec, logic is_irq,
                                              logic [CauseCodeW-1:0] code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && is_irq) begin
      base = base + {25'b0, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Interrupt eligibility and fixed-priority selection (MEI > MSI > MTI).
module irq_priority_enc
  import irq_trap_sequencer_pkg::*;
(
  input  logic                  msip,
  input  logic                  mtip,
  input  logic                  meip,
  input  logic [31:0]           mie_bits,
  input  logic                  mstatus_mie,
  input  logic [1:0]            priv,
  output logic                  irq_valid,
  output logic [CauseCodeW-1:0] irq_code
);

  logic global_en;
  logic mei_en, msi_en, mti_en;
  logic unused_mie;

  // Below machine mode interrupts are always globally enabled.
  assign global_en = (priv != 2'b11) | mstatus_mie;

  assign mei_en = meip & mie_bits[IrqMei] & global_en;
  assign msi_en = msip & mie_bits[IrqMsi] & global_en;
  assign mti_en = mtip & mie_bits[IrqMti] & global_en;

  assign unused_mie = ^{mie_bits[31:12], mie_bits[10:8], mie_bits[6:4], mie_bits[2:0]};

  always_comb begin
    irq_valid = 1'b0;
    irq_code  = '0;
    if (mei_en) begin
      irq_valid = 1'b1;
      irq_code  = CauseCodeW'(IrqMei);
    end else if (msi_en) begin
      irq_valid = 1'b1;
      irq_code  = CauseCodeW'(IrqMsi);
    end else if (mti_en) begin
      irq_valid = 1'b1;
      irq_code  = CauseCodeW'(IrqMti);
    end
  end

endmodule

// File: rtl/irq_trap_sequencer.sv
// Trap entry sequencer: selects an exception or interrupt, drains the pipeline,
// commits the trap to the CSR file and redirects fetch to the trap vector.
module irq_trap_sequencer
  import irq_trap_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic [31:0] irq_pc,
  input  logic        msip,
  input  logic        mtip,
  input  logic        meip,
  input  logic [31:0] mie_bits,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv,
  input  logic [31:0] mtvec,
  input  logic        pipe_idle,
  output logic        flush_req,
  output logic        trap_valid,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_tval,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        drain_timeout
);

  localparam int unsigned CntW = ($clog2(DRAIN_MAX + 1) > 4) ? $clog2(DRAIN_MAX + 1) : 4;
  localparam logic [CntW:0] DrainMax = (CntW + 1)'(DRAIN_MAX);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic [CntW:0]         cnt_inc;
  logic                  drain_full;
  logic [31:0]           cause_q, epc_q, tval_q;
  logic                  timeout_q;
  logic                  irq_valid;
  logic [CauseCodeW-1:0] irq_code;
  logic                  sel_valid;

  irq_priority_enc u_irq_priority_enc (
    .msip        (msip),
    .mtip        (mtip),
    .meip        (meip),
    .mie_bits    (mie_bits),
    .mstatus_mie (mstatus_mie),
    .priv        (priv),
    .irq_valid   (irq_valid),
    .irq_code    (irq_code)
  );

  assign sel_valid = exc_valid | irq_valid;

  // Counts this DRAIN cycle too, so DRAIN lasts at most DRAIN_MAX cycles.
  assign cnt_inc    = {1'b0, cnt_q} + (CntW + 1)'(1);
  assign drain_full = cnt_inc >= DrainMax;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (sel_valid) state_d = StDrain;
      StDrain:    if (pipe_idle || drain_full) state_d = StCommit;
      StCommit:   state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StIdle && sel_valid) begin
        // Synchronous exceptions win over any pending interrupt.
        cause_q <= exc_valid ? {27'b0, exc_cause} : {1'b1, 26'b0, irq_code};
        epc_q   <= exc_valid ? exc_pc : irq_pc;
        tval_q  <= exc_valid ? exc_tval : 32'b0;
        cnt_q   <= '0;
      end
      if (state_q == StDrain) begin
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        if (!pipe_idle && drain_full) timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    flush_req      = 1'b0;
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b1;
    unique case (state_q)
      StIdle:     busy = 1'b0;
      StDrain:    flush_req = 1'b1;
      StCommit:   trap_valid = 1'b1;
      StRedirect: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_vector(mtvec, cause_q[31], cause_q[CauseCodeW-1:0]);
      end
      default:    busy = 1'b0;
    endcase
  end

  assign trap_cause    = cause_q;
  assign trap_epc      = epc_q;
  assign trap_tval     = tval_q;
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Self-checking bench for irq_trap_sequencer: directed scenarios plus randomized traps
// checked against a cycle-schedule reference model.
module tb_irq_trap_sequencer;

  localparam int DrainMax = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, irq_pc;
  logic        msip, mtip, meip;
  logic [31:0] mie_bits;
  logic        mstatus_mie;
  logic [1:0]  priv;
  logic [31:0] mtvec;
  logic        pipe_idle;
  logic        flush_req, trap_valid, redirect_valid, busy, drain_timeout;
  logic [31:0] trap_cause, trap_epc, trap_tval, redirect_pc;

  int n_checks = 0;
  int n_errors = 0;
  bit model_timeout = 0;

  irq_trap_sequencer #(.DRAIN_MAX(DrainMax)) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .irq_pc         (irq_pc),
    .msip           (msip),
    .mtip           (mtip),
    .meip           (meip),
    .mie_bits       (mie_bits),
    .mstatus_mie    (mstatus_mie),
    .priv           (priv),
    .mtvec          (mtvec),
    .pipe_idle      (pipe_idle),
    .flush_req      (flush_req),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .trap_tval      (trap_tval),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; irq_pc = 0;
    msip = 0; mtip = 0; meip = 0; mie_bits = 0; mstatus_mie = 0; priv = 0;
    mtvec = 0; pipe_idle = 1;
  endtask

  // Reference selection straight from the trap rules.
  function automatic void model_select(output bit v, output logic [31:0] c,
                                       output logic [31:0] e, output logic [31:0] t);
    int codes[3];
    bit pend[3];
    codes = '{11, 3, 7};
    pend  = '{meip, msip, mtip};
    v = 0; c = 0; e = 0; t = 0;
    if (exc_valid) begin
      v = 1; c = 32'(exc_cause); e = exc_pc; t = exc_tval;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (pend[i] && mie_bits[codes[i]] && (priv != 2'd3 || mstatus_mie)) begin
        v = 1; c = 32'h8000_0000 + 32'(codes[i]); e = irq_pc; t = 0;
        return;
      end
    end
  endfunction

  function automatic logic [31:0] model_vector(logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & ~32'h3;
    if (mtvec[1:0] == 2'b01 && cause[31]) base = base + 4 * (cause & 32'h1f);
    return base;
  endfunction

  // Inputs already applied in IDLE. mode: 0 hold, 1 randomize, 2 drop all requests in DRAIN.
  task automatic run_trap(input string name, input int stall, input int mode, input bit hold);
    bit v;
    logic [31:0] ec, ee, et;
    logic [3:0] st;
    int dlen;
    model_select(v, ec, ee, et);
    dlen = (stall + 1 < DrainMax) ? stall + 1 : DrainMax;
    @(posedge clk);
    for (int k = 0; k < dlen; k++) begin
      @(negedge clk);
      pipe_idle = (k >= stall);
      if (mode == 1) begin
        exc_valid = 1'($urandom); exc_cause = 5'($urandom); exc_pc = $urandom;
        exc_tval = $urandom; irq_pc = $urandom;
        msip = 1'($urandom); mtip = 1'($urandom); meip = 1'($urandom);
      end else if (mode == 2) begin
        exc_valid = 0; msip = 0; mtip = 0; meip = 0;
      end
      st = {flush_req, busy, trap_valid, redirect_valid};
      n_checks++;
      if (st !== 4'b1100) begin
        n_errors++;
        $display("FAIL %s drain[%0d] strobes got %b want 1100", name, k, st);
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (stall >= DrainMax) model_timeout = 1;
    st = {flush_req, busy, trap_valid, redirect_valid};
    n_checks++;
    if (st !== 4'b0110) begin
      n_errors++;
      $display("FAIL %s commit strobes got %b want 0110", name, st);
    end
    n_checks++;
    if ({trap_cause, trap_epc, trap_tval} !== {ec, ee, et}) begin
      n_errors++;
      $display("FAIL %s commit cause/epc/tval got %h/%h/%h want %h/%h/%h", name,
               trap_cause, trap_epc, trap_tval, ec, ee, et);
    end
    n_checks++;
    if (drain_timeout !== model_timeout) begin
      n_errors++;
      $display("FAIL %s drain_timeout got %b want %b", name, drain_timeout, model_timeout);
    end
    @(posedge clk);
    @(negedge clk);
    st = {flush_req, busy, trap_valid, redirect_valid};
    n_checks++;
    if (st !== 4'b0101 || redirect_pc !== model_vector(ec)) begin
      n_errors++;
      $display("FAIL %s redirect strobes %b pc %h want 0101 pc %h", name, st, redirect_pc,
               model_vector(ec));
    end
    pipe_idle = 1;
    if (!hold) begin
      exc_valid = 0; msip = 0; mtip = 0; meip = 0;
    end
    @(posedge clk);
    @(negedge clk);
    st = {flush_req, busy, trap_valid, redirect_valid};
    n_checks++;
    if (st !== 4'b0000 || trap_cause !== ec || redirect_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL %s idle strobes %b cause %h rpc %h want 0000 %h 0", name, st,
               trap_cause, redirect_pc, ec);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({flush_req, trap_valid, trap_cause, trap_epc, trap_tval, redirect_valid, redirect_pc,
         busy, drain_timeout} !== '0) begin
      n_errors++;
      $display("FAIL %s outputs not zero: flush %b tv %b cause %h epc %h tval %h rv %b rpc %h busy %b to %b",
               name, flush_req, trap_valid, trap_cause, trap_epc, trap_tval, redirect_valid,
               redirect_pc, busy, drain_timeout);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_exception();
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD; mtvec = 32'h800;
    run_trap("exception", 0, 0, 0);
  endtask

  task automatic test_vectored_irq();
    meip = 1; mtip = 1; mie_bits = (32'h1 << 11) | (32'h1 << 7); mstatus_mie = 1; priv = 3;
    mtvec = 32'h801; irq_pc = 32'h2000;
    run_trap("vectored_mei", 1, 0, 0);
  endtask

  task automatic test_eligibility();
    mtip = 1; mie_bits = 32'h1 << 7; mstatus_mie = 0; priv = 3; mtvec = 32'h400;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({busy, flush_req} !== 2'b00) begin
        n_errors++;
        $display("FAIL masked_mti busy/flush got %b%b want 00", busy, flush_req);
      end
    end
    priv = 1;
    run_trap("mti_user", 2, 0, 0);
  endtask

  task automatic test_msip_drop();
    msip = 1; mie_bits = 32'h1 << 3; priv = 0; mtvec = 32'h1001; irq_pc = 32'h3000;
    run_trap("msip_drop", 4, 2, 0);
  endtask

  task automatic test_back_to_back();
    exc_valid = 1; exc_cause = 5'd13; exc_pc = 32'h4444; exc_tval = 32'h55; mtvec = 32'h900;
    run_trap("b2b_first", 0, 0, 1);
    run_trap("b2b_second", 2, 0, 0);
  endtask

  task automatic test_timeout();
    exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h800; exc_tval = 32'h77; mtvec = 32'h1000;
    run_trap("timeout", 20, 1, 0);
  endtask

  task automatic test_random();
    bit v;
    logic [31:0] c, e, t;
    for (int i = 0; i < 40; i++) begin
      exc_valid = ($urandom_range(0, 2) == 0); exc_cause = 5'($urandom);
      exc_pc = $urandom; exc_tval = $urandom; irq_pc = $urandom;
      msip = 1'($urandom); mtip = 1'($urandom); meip = 1'($urandom);
      mie_bits = $urandom; mstatus_mie = 1'($urandom); priv = 2'($urandom);
      mtvec = $urandom;
      model_select(v, c, e, t);
      if (v) begin
        run_trap("random", $urandom_range(0, 17), $urandom_range(0, 1), 0);
      end else begin
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
          n_errors++;
          $display("FAIL random_no_trap busy got %b want 0", busy);
        end
      end
    end
  endtask

  task automatic test_reset_in_commit();
    exc_valid = 1; exc_cause = 5'd7; exc_pc = 32'h600; exc_tval = 32'h9; mtvec = 32'h700;
    @(posedge clk);
    @(negedge clk);
    exc_valid = 0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (trap_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_commit pre trap_valid got %b want 1", trap_valid);
    end
    rst = 1;
    #1;
    model_timeout = 0;
    check_all_zero("reset_in_commit");
    @(negedge clk);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({busy, trap_valid, redirect_valid} !== 3'b000) begin
        n_errors++;
        $display("FAIL reset_commit after busy/tv/rv got %b%b%b want 000", busy, trap_valid,
                 redirect_valid);
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    test_reset();
    test_exception();
    clear_inputs();
    test_vectored_irq();
    clear_inputs();
    test_eligibility();
    clear_inputs();
    test_msip_drop();
    clear_inputs();
    test_back_to_back();
    clear_inputs();
    test_timeout();
    clear_inputs();
    test_random();
    clear_inputs();
    test_reset_in_commit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
